// File: rtl/sample_capture.sv
// Triggered, decimated multi-channel capture engine. Samples land in a
// show-ahead FIFO and stream out over valid/ready with a last marker.
module sample_capture #(
  parameter int CHANNELS = 2,
  parameter int CH_WIDTH = 8,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 32,
  parameter int DEC_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*CH_WIDTH-1:0] sample_in,
  input  logic                         arm,
  input  logic                         abort,
  input  logic [1:0]                   trig_mode,
  input  logic [CHANNELS*CH_WIDTH-1:0] trig_mask,
  input  logic [CHANNELS*CH_WIDTH-1:0] trig_value,
  input  logic [CNT_W-1:0]             total_samples,
  input  logic [DEC_W-1:0]             decim,
  output logic [CHANNELS*CH_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [$clog2(DEPTH):0]       level
);
  localparam int DW = CHANNELS*CH_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [DW-1:0]    mask;
    logic [DW-1:0]    value;
    logic [CNT_W-1:0] total;
    logic [DEC_W-1:0] decim;
  } cfg_t;

  state_t           state, state_nxt;
  cfg_t             cfg;
  logic [CNT_W-1:0] cap_cnt;
  logic [DEC_W-1:0] dec_cnt;
  logic             prev_match;

  logic [DW:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [DW:0]      head;

  logic             idle_like, arm_go, flush, take, take_last, full, push, pop;
  logic             match, trig_fire;
  logic [DW-1:0]    eff_mask, eff_value;
  logic [CHANNELS-1:0] ch_match;

  // Outside a run the live match pattern feeds prev_match, so an edge
  // trigger sees the true pre-arm match level on its first ARMED cycle.
  assign idle_like = (state == IDLE) || (state == DONE);
  assign eff_mask  = idle_like ? trig_mask  : cfg.mask;
  assign eff_value = idle_like ? trig_value : cfg.value;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch_match[k] = ((sample_in[k*CH_WIDTH +: CH_WIDTH] ^ eff_value[k*CH_WIDTH +: CH_WIDTH])
                          & eff_mask[k*CH_WIDTH +: CH_WIDTH]) == '0;
  end
  assign match = &ch_match;

  always_comb begin
    case (cfg.mode)
      2'd1:    trig_fire = match;
      2'd2:    trig_fire = match & ~prev_match;
      default: trig_fire = 1'b1;
    endcase
  end

  assign arm_go    = !abort && arm && idle_like;
  assign flush     = abort || arm_go;
  assign take      = !abort && (((state == ARMED) && trig_fire) || ((state == CAPTURE) && (dec_cnt == '0)));
  assign take_last = (cap_cnt + CNT_W'(1)) == cfg.total;
  // Overflow is judged on pre-pop occupancy.
  assign full      = level == LW'(DEPTH);
  assign push      = take && !full;
  assign out_valid = level != '0;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign out_last  = out_valid & head[DW];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE, DONE: if (arm) state_nxt = (total_samples == '0) ? DONE : ARMED;
        ARMED:      if (trig_fire) state_nxt = take_last ? DRAIN : CAPTURE;
        CAPTURE:    if (take && take_last) state_nxt = DRAIN;
        DRAIN:      if (level == '0) state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == ARMED) || (state == CAPTURE) || (state == DRAIN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg        <= '0;
      cap_cnt    <= '0;
      dec_cnt    <= '0;
      prev_match <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
    end else begin
      prev_match <= match;
      if (arm_go) begin
        cfg      <= '{mode: trig_mode, mask: trig_mask, value: trig_value,
                      total: total_samples, decim: decim};
        overflow <= 1'b0;
        cap_cnt  <= '0;
      end
      if (take) begin
        cap_cnt <= cap_cnt + CNT_W'(1);
        dec_cnt <= cfg.decim;
        if (full) overflow <= 1'b1;
      end else if (state == CAPTURE) begin
        dec_cnt <= dec_cnt - DEC_W'(1);
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        level <= level + LW'(push) - LW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {take_last, sample_in};
  end

endmodule

// File: doc/sample_capture.md
# sample_capture

Parametrised, synthesizable capture engine. It samples a wide multi-channel bus (for example a chip's `uo_out`/`uio_out` pair) once per sample interval after an arm request and an optional trigger. Samples are buffered in an internal FIFO and streamed out over a valid/ready interface with a last marker. It sits beside the design under test, both on-chip and in bench harnesses, and replaces fixed-length per-cycle dumping with triggered, decimated, bounded capture.

## Interface
- `CHANNELS`, default 2: number of sampled channels.
- `CH_WIDTH`, default 8: bits per channel. `DW = CHANNELS*CH_WIDTH`.
- `DEPTH`, default 16: FIFO entries; power of two, ≥2.
- `CNT_W`, default 32: sample-count width.
- `DEC_W`, default 8: decimation field width.

Ports:
- `clk` in 1: single clock. Everything is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `sample_in` in DW: bus being captured. Channel k occupies bits `[k*CH_WIDTH +: CH_WIDTH]`.
- `arm` in 1: start request; honoured only in IDLE or DONE.
- `abort` in 1: return to IDLE and flush the FIFO. Takes priority over `arm`.
- `trig_mode` in 2: 0 = immediate, 1 = level match, 2 = rising edge of match, 3 = reserved (behaves as 0).
- `trig_mask`, `trig_value` in DW: match is `(sample_in & trig_mask) == (trig_value & trig_mask)`.
- `total_samples` in CNT_W: number of samples to capture.
- `decim` in DEC_W: capture one sample every `decim+1` cycles.
- `out_data` out DW: FIFO head.
- `out_valid` out 1: head is valid.
- `out_ready` in 1: consumer accepts the beat when `out_valid && out_ready`.
- `out_last` out 1: head is the final captured sample.
- `busy` out 1: state is ARMED, CAPTURE or DRAIN.
- `done` out 1: state is DONE.
- `overflow` out 1: sticky; at least one sample was dropped in this run.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- States are IDLE, ARMED, CAPTURE, DRAIN and DONE.
- Reset leaves the block in IDLE with an empty FIFO. All outputs read 0: `out_data`, `out_valid`, `out_last`, `busy`, `done`, `overflow` and `level`.
- **IDLE/DONE + arm:**
  - `trig_mode`, mask, value, `total_samples` and `decim` are latched.
  - `overflow` is cleared and the FIFO is flushed.
  - Next state is ARMED, or DONE directly if `total_samples == 0`; no beats are emitted in that case.
- **Trigger:** evaluated each cycle in ARMED.
  - Immediate: fires on the first ARMED cycle.
  - Level: fires on the first ARMED cycle with match = 1.
  - Edge: fires when match = 1 and `prev_match` = 0.
  - `prev_match` is a register updated every cycle in every state; reset value 0.
- **On trigger:** the `sample_in` of the trigger cycle is the first captured sample. The state moves to CAPTURE and the decimation counter is loaded with `decim`.
- **CAPTURE:**
  - A sample is taken when the decimation counter is 0, and the counter then reloads with `decim`. Otherwise the counter decrements.
  - Every taken sample increments the captured count.
  - The sample equal to `total_samples` is pushed with its last bit set, and the state moves to DRAIN.
- **Full FIFO:** a sample taken while `level == DEPTH` is dropped, judged on pre-pop occupancy even if a pop happens in the same cycle.
  - `overflow` is set.
  - The dropped sample still counts toward `total_samples`.
  - If the final sample is dropped, no beat carries `out_last`.
- **DRAIN:** moves to DONE in the cycle after the FIFO becomes empty.
- **DONE:** holds until `arm`, `abort` or reset.
- **abort:** from any state, next state is IDLE. The FIFO is flushed, `out_valid` drops, and `overflow` is kept.
- **Reset mid-operation:** identical to power-on reset.

## Timing
- A sample taken on edge t appears on `out_data`/`out_valid` after edge t, i.e. one cycle of latency. The FIFO is show-ahead.
- Back-to-back beats are possible: `decim = 0` with `out_ready = 1` gives one beat per cycle.
- `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- Simultaneous push and pop with the FIFO not full leaves `level` unchanged. Pop when empty is impossible because `out_valid = 0`.
- `busy` and `done` change on the edge of the state transition.
- Arm-to-first-sample latency, immediate mode: the arm edge moves the state to ARMED, and the first capture is on the next edge.

## Test plan
- **Immediate capture:** `trig_mode=0`, `total=4`, `decim=0`, `out_ready=1`, `sample_in = 0x0100+n`. Expect 4 consecutive beats with increasing values and `out_last` only on the 4th. `done=1` two cycles after the last push, `overflow=0`.
- **Level trigger:** mask 0x00FF, value 0x0010, `sample_in` counting from 0x0000. First beat is 0x0010; exactly `total` beats follow.
- **Edge trigger with match already high at arm:** no capture until match goes 0 then 1. The first beat equals the value at the 0→1 cycle.
- **Decimation:** `decim=2`, `total=3`, counter input. Beats are n, n+3, n+6, and the last beat is n+6.
- **Overflow:** `DEPTH=16`, `out_ready=0`, `total=20`. `level` saturates at 16 and `overflow=1`. Then raise `out_ready`: 16 beats, no `out_last`, then `done=1`.
- **Abort and reset:** abort mid-CAPTURE returns to IDLE with `out_valid=0` and `level=0` next cycle. `rst_n=0` mid-DRAIN forces all outputs to 0; re-arm then captures correctly.
